// File: rtl/i2si_rx_param_if.sv
// Consumer-side bus of the I2S receive deserializer.
//   i2si_lft / i2si_rgt : delivered stereo pair (DATA_W bits each)
//   i2si_vld            : pair valid, held until i2si_ack
//   i2si_xfc            : one-cycle pulse per delivered pair
//   i2si_ovr            : one-cycle pulse, pair delivered over an unacknowledged one
//   i2si_short          : one-cycle pulse, slot closed with fewer than DATA_W bits
//   i2si_ack            : consumer acknowledge of the current pair
// master = deserializer, slave = audio datapath / register file.
interface i2si_rx_param_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] i2si_lft;
    logic [DATA_W-1:0] i2si_rgt;
    logic              i2si_vld;
    logic              i2si_xfc;
    logic              i2si_ovr;
    logic              i2si_short;
    logic              i2si_ack;

    modport master (
        output i2si_lft,
        output i2si_rgt,
        output i2si_vld,
        output i2si_xfc,
        output i2si_ovr,
        output i2si_short,
        input  i2si_ack
    );

    modport slave (
        input  i2si_lft,
        input  i2si_rgt,
        input  i2si_vld,
        input  i2si_xfc,
        input  i2si_ovr,
        input  i2si_short,
        output i2si_ack
    );
endinterface

// File: rtl/i2si_rx_param.sv
// Parameterised I2S / left-justified receive deserializer in the clk domain.
//   clk, rst              : system clock, synchronous active-high reset
//   i2si_sck/ws/sd        : asynchronous I2S bit clock, word select, serial data
//   rf_i2si_en            : receiver enable
//   rf_i2si_mode          : 0 = I2S (MSB one bit after WS edge), 1 = left-justified
//   bus (master)          : delivered pair, valid/ack handshake and status pulses
module i2si_rx_param #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i2si_sck,
    input  logic                   i2si_ws,
    input  logic                   i2si_sd,
    input  logic                   rf_i2si_en,
    input  logic                   rf_i2si_mode,
    i2si_rx_param_if.master        bus
);

    localparam int unsigned       CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DATA_W);
    localparam logic [DATA_W-1:0] MSB_BIT  = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ACTIVE
    } state_t;

    // Input synchronisers, identical depth so sck/ws/sd stay aligned
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ws_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic                   sck_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
            sck_d    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], i2si_sck};
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], i2si_ws};
            sd_sync  <= {sd_sync[SYNC_STAGES-2:0], i2si_sd};
            sck_d    <= sck_sync[SYNC_STAGES-1];
        end
    end

    logic sck_s;
    logic ws_s;
    logic sd_s;
    logic sck_rise;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign ws_s     = ws_sync[SYNC_STAGES-1];
    assign sd_s     = sd_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;

    // Registered state
    state_t            state_q,      state_d;
    logic              mode_q,       mode_d;
    logic              ws_last_q,    ws_last_d;
    logic [DATA_W-1:0] slot_q,       slot_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic              ch_q,         ch_d;
    logic              left_ok_q,    left_ok_d;
    logic [DATA_W-1:0] left_stage_q, left_stage_d;
    logic [DATA_W-1:0] lft_q,        lft_d;
    logic [DATA_W-1:0] rgt_q,        rgt_d;
    logic              vld_q,        vld_d;
    logic              xfc_q,        xfc_d;
    logic              ovr_q,        ovr_d;
    logic              short_q,      short_d;

    // Bit insertion: the mask walks down from the MSB and vanishes once the
    // counter saturates, so surplus bits of a long slot are dropped for free.
    logic              ws_chg;
    logic [DATA_W-1:0] bit_mask;
    logic [DATA_W-1:0] slot_wr;
    logic [CNT_W-1:0]  cnt_inc;
    logic [DATA_W-1:0] lj_open;

    assign ws_chg   = ws_s ^ ws_last_q;
    assign bit_mask = MSB_BIT >> cnt_q;
    assign slot_wr  = sd_s ? (slot_q | bit_mask) : slot_q;
    assign cnt_inc  = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);
    assign lj_open  = sd_s ? MSB_BIT : '0;

    logic              close;
    logic [DATA_W-1:0] close_word;
    logic [CNT_W-1:0]  close_cnt;

    // Next-state, slot capture and delivery
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        ws_last_d    = ws_last_q;
        slot_d       = slot_q;
        cnt_d        = cnt_q;
        ch_d         = ch_q;
        left_ok_d    = left_ok_q;
        left_stage_d = left_stage_q;
        lft_d        = lft_q;
        rgt_d        = rgt_q;
        vld_d        = vld_q;
        xfc_d        = 1'b0;
        ovr_d        = 1'b0;
        short_d      = 1'b0;
        close        = 1'b0;
        close_word   = '0;
        close_cnt    = '0;

        // ws history is tracked in every state so SYNC never sees a stale edge
        if (sck_rise) begin
            ws_last_d = ws_s;
        end

        if (vld_q && bus.i2si_ack) begin
            vld_d = 1'b0;
        end

        if (!rf_i2si_en) begin
            state_d   = ST_IDLE;
            slot_d    = '0;
            cnt_d     = '0;
            left_ok_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    mode_d  = rf_i2si_mode;
                    state_d = ST_SYNC;
                end
                ST_SYNC: begin
                    mode_d = rf_i2si_mode;
                    // A 1->0 ws edge opens a left slot; everything before is discarded
                    if (sck_rise && ws_chg && !ws_s) begin
                        state_d   = ST_ACTIVE;
                        ch_d      = 1'b0;
                        left_ok_d = 1'b0;
                        if (rf_i2si_mode) begin
                            slot_d = lj_open;
                            cnt_d  = CNT_W'(1);
                        end else begin
                            slot_d = '0;
                            cnt_d  = '0;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (sck_rise) begin
                        if (!ws_chg) begin
                            slot_d = slot_wr;
                            cnt_d  = cnt_inc;
                        end else begin
                            close = 1'b1;
                            ch_d  = ws_s;
                            if (!mode_q) begin
                                // I2S: the edge bit is still the old slot's LSB
                                close_word = slot_wr;
                                close_cnt  = cnt_inc;
                                slot_d     = '0;
                                cnt_d      = '0;
                            end else begin
                                // LJ: the edge bit is already the new slot's MSB
                                close_word = slot_q;
                                close_cnt  = cnt_q;
                                slot_d     = lj_open;
                                cnt_d      = CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Slot close: stage left, deliver on right when a left is staged
        if (close) begin
            short_d = (close_cnt < CNT_FULL);
            if (!ch_q) begin
                left_stage_d = close_word;
                left_ok_d    = 1'b1;
            end else begin
                left_ok_d = 1'b0;
                if (left_ok_q) begin
                    lft_d = left_stage_q;
                    rgt_d = close_word;
                    xfc_d = 1'b1;
                    vld_d = 1'b1;
                    ovr_d = vld_q && !bus.i2si_ack;
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= 1'b0;
            ws_last_q    <= 1'b0;
            slot_q       <= '0;
            cnt_q        <= '0;
            ch_q         <= 1'b0;
            left_ok_q    <= 1'b0;
            left_stage_q <= '0;
            lft_q        <= '0;
            rgt_q        <= '0;
            vld_q        <= 1'b0;
            xfc_q        <= 1'b0;
            ovr_q        <= 1'b0;
            short_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            ws_last_q    <= ws_last_d;
            slot_q       <= slot_d;
            cnt_q        <= cnt_d;
            ch_q         <= ch_d;
            left_ok_q    <= left_ok_d;
            left_stage_q <= left_stage_d;
            lft_q        <= lft_d;
            rgt_q        <= rgt_d;
            vld_q        <= vld_d;
            xfc_q        <= xfc_d;
            ovr_q        <= ovr_d;
            short_q      <= short_d;
        end
    end

    assign bus.i2si_lft   = lft_q;
    assign bus.i2si_rgt   = rgt_q;
    assign bus.i2si_vld   = vld_q;
    assign bus.i2si_xfc   = xfc_q;
    assign bus.i2si_ovr   = ovr_q;
    assign bus.i2si_short = short_q;

endmodule

// File: tb/tb_i2si_rx_param.sv
// Bench for i2si_rx_param: a 16-bit and a 24-bit receiver share one serial
// stream; expected words come from a frame-level model of slot truncation /
// zero-fill, and pulse counts from per-frame rules.
module tb_i2si_rx_param;

    logic clk = 1'b0;
    logic rst, sck, ws, sd, en, mode, ack;

    always #5 clk = ~clk;

    i2si_rx_param_if #(.DATA_W(16)) b16 ();
    i2si_rx_param_if #(.DATA_W(24)) b24 ();

    assign b16.i2si_ack = ack;
    assign b24.i2si_ack = ack;

    i2si_rx_param #(.DATA_W(16), .SYNC_STAGES(2)) u16 (
        .clk(clk), .rst(rst), .i2si_sck(sck), .i2si_ws(ws), .i2si_sd(sd),
        .rf_i2si_en(en), .rf_i2si_mode(mode), .bus(b16)
    );

    i2si_rx_param #(.DATA_W(24), .SYNC_STAGES(3)) u24 (
        .clk(clk), .rst(rst), .i2si_sck(sck), .i2si_ws(ws), .i2si_sd(sd),
        .rf_i2si_en(en), .rf_i2si_mode(mode), .bus(b24)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Output monitor: captures delivered pairs and counts status pulses
    logic [31:0] l16 [0:63];
    logic [31:0] r16 [0:63];
    logic [31:0] l24 [0:63];
    logic [31:0] r24 [0:63];
    int nx16 = 0, ns16 = 0, no16 = 0, nw16 = 0;
    int nx24 = 0, ns24 = 0, no24 = 0, nw24 = 0;
    logic px16 = 0, po16 = 0, ps16 = 0, px24 = 0, po24 = 0, ps24 = 0;

    always @(negedge clk) begin
        if (b16.i2si_xfc) begin
            l16[nx16[5:0]] = 32'(b16.i2si_lft);
            r16[nx16[5:0]] = 32'(b16.i2si_rgt);
            nx16++;
        end
        if (b24.i2si_xfc) begin
            l24[nx24[5:0]] = 32'(b24.i2si_lft);
            r24[nx24[5:0]] = 32'(b24.i2si_rgt);
            nx24++;
        end
        ns16 += int'(b16.i2si_short);
        no16 += int'(b16.i2si_ovr);
        ns24 += int'(b24.i2si_short);
        no24 += int'(b24.i2si_ovr);
        if ((b16.i2si_xfc && px16) || (b16.i2si_ovr && po16) || (b16.i2si_short && ps16)) nw16++;
        if ((b24.i2si_xfc && px24) || (b24.i2si_ovr && po24) || (b24.i2si_short && ps24)) nw24++;
        px16 = b16.i2si_xfc; po16 = b16.i2si_ovr; ps16 = b16.i2si_short;
        px24 = b24.i2si_xfc; po24 = b24.i2si_ovr; ps24 = b24.i2si_short;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a slot of len bits delivered into a w-bit word, MSB aligned
    function automatic logic [31:0] exp_word(input int w, input logic [63:0] v, input int len);
        logic [63:0] t;
        if (len >= w) t = v >> (len - w);
        else          t = v << (w - len);
        t = t & ((64'd1 << w) - 64'd1);
        return t[31:0];
    endfunction

    function automatic logic [63:0] rnd(input int len);
        logic [63:0] v;
        v = {$urandom, $urandom};
        if (len < 64) v = v & ((64'd1 << len) - 64'd1);
        return v;
    endfunction

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One serial bit: ws/sd change while sck is low, 4-clk phases
    task automatic send_bit(input logic w, input logic d);
        ws = w;
        sd = d;
        clks(4);
        sck = 1'b1;
        clks(4);
        sck = 1'b0;
    endtask

    // I2S flips ws on the slot's last bit; LJ keeps ws for the whole slot
    task automatic send_slot(input logic [63:0] v, input int len, input logic ch);
        for (int i = len - 1; i >= 0; i--) begin
            send_bit((mode == 1'b0 && i == 0) ? ~ch : ch, v[i]);
        end
    endtask

    // Optional junk left bits, then the tail of a right slot ending at a 1->0 edge
    task automatic preamble(input int jl);
        for (int i = 0; i < jl; i++) send_bit(1'b0, 1'($urandom));
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'($urandom));
        if (mode == 1'b0) send_bit(1'b0, 1'($urandom));
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        clks(1);
        ack = 1'b0;
    endtask

    logic [63:0] fl [0:7];
    logic [63:0] fr [0:7];
    int bx16, bx24, bs16, bs24, bo16, bo24, bw16, bw24;

    task automatic snap();
        bx16 = nx16; bx24 = nx24; bs16 = ns16; bs24 = ns24;
        bo16 = no16; bo24 = no24; bw16 = nw16; bw24 = nw24;
    endtask

    task automatic run_test(input string name, input logic m, input int n, input int ll,
                            input int rl, input bit ack_each, input logic [63:0] fl0,
                            input logic [63:0] fr0, input int jl);
        en = 1'b0;
        ack = 1'b0;
        clks(2);
        mode = m;
        en = 1'b1;
        clks(2);
        snap();
        preamble(jl);
        for (int f = 0; f < n; f++) begin
            fl[f] = (f == 0) ? fl0 : rnd(ll);
            fr[f] = (f == 0) ? fr0 : rnd(rl);
            send_slot(fl[f], ll, 1'b0);
            send_slot(fr[f], rl, 1'b1);
            clks(4);
            if (ack_each) pulse_ack();
        end
        for (int i = 0; i < 2; i++) send_bit(1'b0, 1'($urandom));
        clks(4);
        chk({name, " xfc16"}, 32'(nx16 - bx16), 32'(n));
        chk({name, " xfc24"}, 32'(nx24 - bx24), 32'(n));
        for (int f = 0; f < n; f++) begin
            chk({name, " lft16"}, l16[6'(bx16 + f)], exp_word(16, fl[f], ll));
            chk({name, " rgt16"}, r16[6'(bx16 + f)], exp_word(16, fr[f], rl));
            chk({name, " lft24"}, l24[6'(bx24 + f)], exp_word(24, fl[f], ll));
            chk({name, " rgt24"}, r24[6'(bx24 + f)], exp_word(24, fr[f], rl));
        end
        chk({name, " short16"}, 32'(ns16 - bs16), 32'(n * (int'(ll < 16) + int'(rl < 16))));
        chk({name, " short24"}, 32'(ns24 - bs24), 32'(n * (int'(ll < 24) + int'(rl < 24))));
        chk({name, " ovr16"}, 32'(no16 - bo16), 32'(ack_each ? 0 : n - 1));
        chk({name, " ovr24"}, 32'(no24 - bo24), 32'(ack_each ? 0 : n - 1));
        chk({name, " wide16"}, 32'(nw16 - bw16), 32'd0);
        chk({name, " wide24"}, 32'(nw24 - bw24), 32'd0);
        if (!ack_each) begin
            chk({name, " vld held"}, 32'(b16.i2si_vld), 32'd1);
            chk({name, " out lft16"}, 32'(b16.i2si_lft), exp_word(16, fl[n-1], ll));
            chk({name, " out rgt24"}, 32'(b24.i2si_rgt), exp_word(24, fr[n-1], rl));
            ack = 1'b1;
            chk({name, " vld before ack edge"}, 32'(b16.i2si_vld), 32'd1);
            clks(1);
            ack = 1'b0;
            chk({name, " vld after ack16"}, 32'(b16.i2si_vld), 32'd0);
            chk({name, " vld after ack24"}, 32'(b24.i2si_vld), 32'd0);
        end
        pulse_ack();
    endtask

    logic [63:0] a, b;

    initial begin
        rst = 1'b1; sck = 1'b0; ws = 1'b0; sd = 1'b0; en = 1'b0; mode = 1'b0; ack = 1'b0;
        clks(3);
        chk("reset lft16", 32'(b16.i2si_lft), 32'd0);
        chk("reset rgt24", 32'(b24.i2si_rgt), 32'd0);
        chk("reset vld", 32'({b16.i2si_vld, b24.i2si_vld}), 32'd0);
        chk("reset pulses", 32'({b16.i2si_xfc, b16.i2si_ovr, b16.i2si_short,
                                 b24.i2si_xfc, b24.i2si_ovr, b24.i2si_short}), 32'd0);
        rst = 1'b0;
        clks(2);

        // I2S, 16-bit slots, known first pair then random, acked each frame
        run_test("i2s16", 1'b0, 3, 16, 16, 1'b1, 64'hA5C3, 64'h1234, 0);
        // LJ, 32-bit slots: truncation, no short
        run_test("lj32", 1'b1, 2, 32, 32, 1'b1, 64'h123456AB, 64'hFEDCBA98, 0);
        // I2S, 12-bit slots: zero-filled LSBs, two shorts per frame
        run_test("i2s12", 1'b0, 2, 12, 12, 1'b1, 64'hABC, 64'h5E7, 0);
        // Two frames without ack: overrun, newest data wins
        run_test("ovr24", 1'b0, 2, 24, 24, 1'b0, rnd(24), rnd(24), 0);
        // Enabled mid-left: junk bits and the following right slot are discarded
        run_test("midleft", 1'b0, 2, 16, 16, 1'b1, rnd(16), rnd(16), 5);
        // LJ with mixed slot lengths and overrun
        run_test("lj_mix", 1'b1, 3, 20, 28, 1'b0, rnd(20), rnd(28), 2);

        // Drop enable mid-left: no delivery, outputs hold
        en = 1'b0; clks(2); mode = 1'b0; en = 1'b1; clks(2);
        preamble(0);
        a = rnd(16); b = rnd(16);
        send_slot(a, 16, 1'b0);
        send_slot(b, 16, 1'b1);
        clks(4);
        snap();
        for (int i = 15; i >= 10; i--) send_bit(1'b0, a[i]);
        en = 1'b0;
        clks(2);
        send_slot(rnd(16), 16, 1'b1);
        send_slot(rnd(16), 16, 1'b0);
        clks(4);
        chk("en drop xfc", 32'(nx16 - bx16 + nx24 - bx24), 32'd0);
        chk("en drop lft16 hold", 32'(b16.i2si_lft), exp_word(16, a, 16));
        chk("en drop rgt24 hold", 32'(b24.i2si_rgt), exp_word(24, b, 16));
        chk("en drop vld hold", 32'(b16.i2si_vld), 32'd1);
        pulse_ack();

        // Reset mid-frame: everything cleared, resume only after a fresh frame
        en = 1'b1; clks(2);
        preamble(0);
        send_slot(rnd(16), 16, 1'b0);
        send_slot(rnd(16), 16, 1'b1);
        clks(4);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'($urandom));
        rst = 1'b1;
        clks(1);
        rst = 1'b0;
        chk("rst lft16", 32'(b16.i2si_lft), 32'd0);
        chk("rst rgt16", 32'(b16.i2si_rgt), 32'd0);
        chk("rst lft24", 32'(b24.i2si_lft), 32'd0);
        chk("rst vld", 32'({b16.i2si_vld, b24.i2si_vld}), 32'd0);
        snap();
        send_slot(rnd(11), 11, 1'b0);
        send_slot(rnd(16), 16, 1'b1);
        clks(4);
        chk("rst partial no xfc", 32'(nx16 - bx16), 32'd0);
        a = rnd(16); b = rnd(16);
        send_slot(a, 16, 1'b0);
        send_slot(b, 16, 1'b1);
        clks(4);
        chk("rst fresh xfc16", 32'(nx16 - bx16), 32'd1);
        chk("rst fresh xfc24", 32'(nx24 - bx24), 32'd1);
        chk("rst fresh lft16", l16[6'(bx16)], exp_word(16, a, 16));
        chk("rst fresh rgt24", r24[6'(bx24)], exp_word(24, b, 16));
        pulse_ack();
        clks(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
